// File: rtl/uart_register_peripheral_pkg.sv
// Shared definitions for the ulisp register-bus UART: register indices, status bit
// positions and the TX/RX state encodings.
package ulisp_periph_defs;

   localparam logic [11:0] REG_CONSOLE = 12'd0;
   localparam logic [11:0] REG_STATUS  = 12'd1;
   localparam logic [11:0] REG_DIVISOR = 12'd2;
   localparam logic [11:0] REG_CONTROL = 12'd3;

   localparam int unsigned ST_RX_AVAIL  = 0;
   localparam int unsigned ST_TX_FULL   = 1;
   localparam int unsigned ST_TX_IDLE   = 2;
   localparam int unsigned ST_OVERRUN   = 3;
   localparam int unsigned ST_FRAME_ERR = 4;

   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
   typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output. Push when full and pop when
// empty are ignored; depth must be a power of two.
module uart_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_register_peripheral.sv
// Register-bus UART (8N1) with TX/RX FIFOs for the ulisp core.
// Define UART_LOOPBACK_EN to add register 3 (bit0 routes uart_tx back into the receiver).
module uart_register_peripheral
   import ulisp_periph_defs::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd217
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] register_index,
   input  logic        register_read,
   input  logic        register_write,
   input  logic [15:0] register_write_value,
   output logic [15:0] register_read_value,
   output logic        uart_tx,
   input  logic        uart_rx
);

   logic        tx_push, tx_pop, tx_full, tx_empty, tx_load;
   logic [7:0]  tx_dout;
   logic        rx_push, rx_pop, rx_full, rx_empty;
   logic [7:0]  rx_dout;
   logic [15:0] div_q, rdata_q, read_data, status;
   logic        frame_err_q, overrun_q, frame_err_set, overrun_set, status_clear;
   logic        rx_line, rx_meta_q, rx_sync_q, rx_prev_q;

   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;

   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;

   assign tx_push      = register_write && (register_index == REG_CONSOLE);
   assign rx_pop       = register_read && (register_index == REG_CONSOLE) && !rx_empty;
   assign status_clear = register_read && (register_index == REG_STATUS);
   assign register_read_value = rdata_q;

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .reset(reset), .push(tx_push), .din(register_write_value[7:0]),
      .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
   );

   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift_q),
      .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
   );

`ifdef UART_LOOPBACK_EN
   logic loopback_q;
   assign rx_line = loopback_q ? uart_tx : uart_rx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) loopback_q <= 1'b0;
      else if (register_write && (register_index == REG_CONTROL))
         loopback_q <= register_write_value[0];
   end
`else
   assign rx_line = uart_rx;
`endif

   always_comb begin
      status = '0;
      status[ST_RX_AVAIL]  = !rx_empty;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_IDLE]   = tx_empty && (tx_state_q == TxIdle);
      status[ST_OVERRUN]   = overrun_q;
      status[ST_FRAME_ERR] = frame_err_q;
      read_data = '0;
      case (register_index)
         REG_CONSOLE: read_data = rx_empty ? 16'h0000 : {8'h00, rx_dout};
         REG_STATUS:  read_data = status;
         REG_DIVISOR: read_data = div_q;
`ifdef UART_LOOPBACK_EN
         REG_CONTROL: read_data = {15'b0, loopback_q};
`endif
         default:     read_data = '0;
      endcase
   end

   // Sticky bits: a set in the same cycle as a status read wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q     <= '0;
         div_q       <= DIV_RESET;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (register_read) rdata_q <= read_data;
         if (register_write && (register_index == REG_DIVISOR))
            div_q <= (register_write_value < DIV_MIN) ? DIV_MIN : register_write_value;
         if (frame_err_set)     frame_err_q <= 1'b1;
         else if (status_clear) frame_err_q <= 1'b0;
         if (overrun_set)       overrun_q <= 1'b1;
         else if (status_clear) overrun_q <= 1'b0;
      end
   end

   // TX: a frame ending with data queued reloads straight into START (no idle gap).
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_load    = 1'b0;
      case (tx_state_q)
         TxIdle:  tx_load = !tx_empty;
         TxStart: if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_state_d = TxData;
         end
         TxData:  if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TxStop;
         end
         TxStop:  if (tx_cnt_q == tx_div_q - 16'd1) begin
            tx_load    = !tx_empty;
            tx_state_d = TxIdle;
         end
         default: tx_state_d = TxIdle;
      endcase
      if (tx_load) begin
         tx_shift_d = tx_dout;
         tx_div_d   = div_q;
         tx_cnt_d   = '0;
         tx_state_d = TxStart;
      end
      tx_pop = tx_load;
      case (tx_state_q)
         TxStart: uart_tx = 1'b0;
         TxData:  uart_tx = tx_shift_q[0];
         default: uart_tx = 1'b1;
      endcase
   end

   always_comb begin
      rx_state_d    = rx_state_q;
      rx_cnt_d      = rx_cnt_q + 16'd1;
      rx_div_d      = rx_div_q;
      rx_bit_d      = rx_bit_q;
      rx_shift_d    = rx_shift_q;
      rx_push       = 1'b0;
      frame_err_set = 1'b0;
      overrun_set   = 1'b0;
      case (rx_state_q)
         RxIdle:  if (rx_prev_q && !rx_sync_q) begin
            rx_cnt_d   = '0;
            rx_div_d   = div_q;
            rx_state_d = RxStart;
         end
         RxStart: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RxIdle : RxData;
         end
         RxData:  if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RxStop;
         end
         RxStop:  if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_state_d = RxIdle;
            if (!rx_sync_q)   frame_err_set = 1'b1;
            else if (rx_full) overrun_set   = 1'b1;
            else              rx_push       = 1'b1;
         end
         default: rx_state_d = RxIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q <= TxIdle;
         tx_cnt_q   <= '0;
         tx_div_q   <= DIV_RESET;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         rx_state_q <= RxIdle;
         rx_cnt_q   <= '0;
         rx_div_q   <= DIV_RESET;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_meta_q  <= rx_line;
         rx_sync_q  <= rx_meta_q;
         rx_prev_q  <= rx_sync_q;
      end
   end

endmodule
